multiplier_interface: RTL and testbench

- Downstream neighbour of the divider interface. Accepts 16-bit packed operand words {a[15:8], b[7:0]}, which are the divider's {quotient, reminder}, into an internal FIFO.
- Reports free FIFO slots back upstream, which gates the upstream write.
- Pops one entry at a time, multiplies a*b with a sequential shift-add core, and presents the 16-bit product on a valid/ready output.

---
 rtl/mult_pkg.sv | 16 +
 rtl/multiplier_interface_if.sv | 27 ++
 rtl/multiplier_interface_core.sv | 58 +++++
 rtl/multiplier_interface.sv | 129 ++++++++++++
 tb/tb_multiplier_interface.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the multiplier interface and its shift-add core.
package mult_pkg;

  localparam int OP_W      = 8;
  localparam int FIFO_AW   = 4;
  localparam int DEPTH     = 2 ** FIFO_AW;
  localparam int CORE_ITER = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CALC  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/multiplier_interface_if.sv
// Upstream write / downstream result bundle of the multiplier interface.
// With MULT_OP_COUNT_EN defined the bundle also carries the op_count output.
interface multiplier_interface_if #(
  parameter int OP_W    = mult_pkg::OP_W,
  parameter int FIFO_AW = mult_pkg::FIFO_AW
);
  logic                write_req;
  logic [2*OP_W-1:0]   in_data;
  logic [FIFO_AW:0]    left_sig;
  logic                ovf_err;
  logic [2*OP_W-1:0]   result;
  logic                out_valid;
  logic                out_ready;
`ifdef MULT_OP_COUNT_EN
  logic [15:0]         op_count;

  modport slave  (input  write_req, in_data, out_ready,
                  output left_sig, ovf_err, result, out_valid, op_count);
  modport master (output write_req, in_data, out_ready,
                  input  left_sig, ovf_err, result, out_valid, op_count);
`else
  modport slave  (input  write_req, in_data, out_ready,
                  output left_sig, ovf_err, result, out_valid);
  modport master (output write_req, in_data, out_ready,
                  input  left_sig, ovf_err, result, out_valid);
`endif
endinterface

// File: rtl/multiplier_interface_core.sv
// Unsigned shift-add multiplier: one partial product per clock, done pulses on the last iteration.
module mult_core_module
  import mult_pkg::*;
#(
  parameter int OP_W = mult_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              done,
  output logic [2*OP_W-1:0] product
);

  localparam int CNT_W = $clog2(CORE_ITER + 1);

  logic [2*OP_W-1:0] acc_q;
  logic [2*OP_W-1:0] mcand_q;
  logic [OP_W-1:0]   mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  // The start edge already performs iteration 0, so eight edges complete the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc_q    <= b[0] ? {{OP_W{1'b0}}, a} : '0;
        mcand_q  <= {{(OP_W-1){1'b0}}, a, 1'b0};
        mplier_q <= b >> 1;
        cnt_q    <= CNT_W'(1);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CORE_ITER - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/multiplier_interface.sv
// Operand FIFO feeding a sequential multiplier with a valid/ready result port.
// Define MULT_OP_COUNT_EN to add the 16-bit handshake counter op_count.
module multiplier_interface
  import mult_pkg::*;
#(
  parameter int OP_W    = mult_pkg::OP_W,
  parameter int FIFO_AW = mult_pkg::FIFO_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  multiplier_interface_if.slave  bus
);

  localparam int               FDEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FDEPTH);

  logic [2*OP_W-1:0] mem [FDEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d, left_q;
  logic [2*OP_W-1:0]  rd_data_q;
  logic               ovf_q;
  logic               push, pop;

  state_e             state_q;
  logic [OP_W-1:0]    a_q, b_q;
  logic               start_q;
  logic [2*OP_W-1:0]  result_q;
  logic               valid_q;
  logic               core_done;
  logic [2*OP_W-1:0]  core_product;

  // Fullness comes from the registered count only; a same-cycle pop never frees a slot.
  assign push = bus.write_req && (left_q != '0);
  assign pop  = (state_q == ST_IDLE) && (count_q != '0);

  // NOTE: every path through a combinational block must assign its outputs, so defaults go first.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is not reset; the pointers and count alone decide which words are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      left_q    <= FULL_CNT;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      left_q  <= FULL_CNT - count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem[rd_ptr_q];
      end
      if (bus.write_req && (left_q == '0)) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (pop) state_q <= ST_FETCH;
        ST_FETCH: begin
          a_q     <= rd_data_q[2*OP_W-1:OP_W];
          b_q     <= rd_data_q[OP_W-1:0];
          start_q <= 1'b1;
          state_q <= ST_CALC;
        end
        ST_CALC: if (core_done) begin
          result_q <= core_product;
          valid_q  <= 1'b1;
          state_q  <= ST_OUT;
        end
        ST_OUT: if (bus.out_ready) begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mult_core_module #(.OP_W(OP_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start_q),
    .a       (a_q),
    .b       (b_q),
    .done    (core_done),
    .product (core_product)
  );

`ifdef MULT_OP_COUNT_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else if (valid_q && bus.out_ready) op_count_q <= op_count_q + 16'd1;
  end

  assign bus.op_count = op_count_q;
`endif

  assign bus.left_sig  = left_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.result    = result_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_multiplier_interface.sv
// Bench for multiplier_interface: product queue model, per-cycle result/backpressure checks, directed vectors.
// Checks op_count as well when MULT_OP_COUNT_EN is defined.
module tb_multiplier_interface;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  multiplier_interface_if bus_if ();

  multiplier_interface dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int          checks   = 0;
  int          failures = 0;
  int          hs_count = 0;
  logic [15:0] exp_q[$];
  logic        prev_hold   = 1'b0;
  logic [15:0] prev_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_mul(input logic [15:0] w);
    logic [15:0] a, b;
    a = {8'd0, w[15:8]};
    b = {8'd0, w[7:0]};
    return a * b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w, input bit accept);
    bus_if.write_req = 1'b1;
    bus_if.in_data   = w;
    if (accept) exp_q.push_back(model_mul(w));
    tick();
    bus_if.write_req = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while (!bus_if.out_valid && n < bound) begin
      tick();
      n++;
    end
    check("wait_valid", bus_if.out_valid, 1);
  endtask

  task automatic wait_drain(input int bound, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic do_op(input logic [15:0] w, input logic [15:0] lit, input string name);
    write_word(w, 1'b1);
    wait_valid(40);
    check(name, bus_if.result, lit);
    tick();
    tick();
  endtask

  // Compare process: every handshake against the model queue, every stalled cycle for stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      hs_count  = 0;
    end else begin
      if (prev_hold) begin
        check("bp_valid_held", bus_if.out_valid, 1);
        check("bp_result_held", bus_if.result, prev_result);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("result_vs_model", bus_if.result, exp_q.pop_front());
        hs_count++;
      end
      prev_hold   = bus_if.out_valid && !bus_if.out_ready;
      prev_result = bus_if.result;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen_valid;

    bus_if.write_req = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    do_reset();

    check("rst_left_sig", bus_if.left_sig, 16);
    check("rst_ovf_err", bus_if.ovf_err, 0);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_result", bus_if.result, 0);
`ifdef MULT_OP_COUNT_EN
    check("rst_op_count", bus_if.op_count, 0);
`endif

    // Single op: latency from write edge to out_valid is 11 edges.
    bus_if.out_ready = 1'b1;
    write_word(16'h0C05, 1'b1);
    check("single_left_push", bus_if.left_sig, 15);
    tick();
    check("single_left_pop", bus_if.left_sig, 16);
    n = 1;
    while (!bus_if.out_valid && n < 40) begin
      tick();
      n++;
    end
    check("single_latency", n, 11);
    check("single_result", bus_if.result, 16'h003C);
    tick();
    check("single_valid_cleared", bus_if.out_valid, 0);
    tick();

    do_op(16'hFFFF, 16'hFE01, "ext_ffff");
    do_op(16'h00FF, 16'h0000, "ext_00ff");
    do_op(16'h0101, 16'h0001, "ext_0101");
`ifdef MULT_OP_COUNT_EN
    check("op_count_singles", bus_if.op_count, 4);
`endif

    // Fill and overflow with the output stalled.
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) write_word({8'(i + 1), 8'(2 * i + 3)}, 1'b1);
    check("fill_left_zero", bus_if.left_sig, 0);
    check("fill_ovf_clear", bus_if.ovf_err, 0);
    write_word(16'hABCD, 1'b0);
    check("fill_ovf_set", bus_if.ovf_err, 1);
    check("fill_left_still_zero", bus_if.left_sig, 0);
    bus_if.out_ready = 1'b1;
    wait_drain(300, "fill_drain");
    check("fill_left_empty", bus_if.left_sig, 16);
    check("fill_ovf_sticky", bus_if.ovf_err, 1);
`ifdef MULT_OP_COUNT_EN
    check("op_count_fill", bus_if.op_count, 21);
`endif

    // Random backpressure over five queued ops.
    bus_if.out_ready = 1'b0;
    write_word(16'h0307, 1'b1);
    write_word(16'h8081, 1'b1);
    write_word(16'hF00F, 1'b1);
    write_word(16'h1111, 1'b1);
    write_word(16'h7F02, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      bus_if.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    bus_if.out_ready = 1'b1;
    check("bp_drain", exp_q.size(), 0);
    tick();
    tick();
    check("bp_idle_after", bus_if.out_valid, 0);

    // Push in the same cycle as an IDLE pop with the FIFO full: push is dropped.
    do_reset();
    check("pp_rst_ovf", bus_if.ovf_err, 0);
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) write_word({8'(i + 20), 8'(i + 5)}, 1'b1);
    check("pp_full_left", bus_if.left_sig, 0);
    wait_valid(40);
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    write_word(16'h1234, 1'b0);
    check("pp_full_ovf", bus_if.ovf_err, 1);
    check("pp_full_left_after", bus_if.left_sig, 1);
    bus_if.out_ready = 1'b1;
    wait_drain(300, "pp_full_drain");
`ifdef MULT_OP_COUNT_EN
    check("op_count_pp", bus_if.op_count, 17);
`endif

    // Push and pop together at count 5: count stays 5.
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word({8'(i + 2), 8'(i + 9)}, 1'b1);
    check("pp5_left_before", bus_if.left_sig, 11);
    wait_valid(40);
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    write_word(16'h0707, 1'b1);
    check("pp5_left_after", bus_if.left_sig, 11);
    bus_if.out_ready = 1'b1;
    wait_drain(200, "pp5_drain");
    check("pp5_left_empty", bus_if.left_sig, 16);

    // Reset four cycles after the core start aborts the operation.
    write_word(16'h0909, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_valid", bus_if.out_valid, 0);
    check("midrst_left", bus_if.left_sig, 16);
    check("midrst_result", bus_if.result, 0);
    check("midrst_ovf", bus_if.ovf_err, 0);
`ifdef MULT_OP_COUNT_EN
    check("midrst_op_count", bus_if.op_count, 0);
`endif
    seen_valid = 1'b0;
    repeat (30) begin
      tick();
      seen_valid = seen_valid | bus_if.out_valid;
    end
    check("midrst_no_stale", seen_valid, 0);
    do_op(16'h0D0B, 16'h008F, "post_reset_op");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
